// File: rtl/beep_player_module.sv
// beep_player_module: pops 8-bit note commands from the beep FIFO and plays
// each one on the passive buzzer pin as a square wave (or a silent rest) for
// (D+1) duration units. Notes play back-to-back until the FIFO is empty.
module beep_player_module #(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned UNIT_CYCLES = 2_500_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       empty_sig,
  output logic       read_req_sig,
  input  logic [7:0] FIFO_read_data,
  input  logic       stop_sig,
  output logic       Pin_Out,
  output logic       busy_sig,
  output logic       done_sig
);

  // The lowest note (C4) has the longest half-period and sets the counter width.
  localparam int unsigned HP_MAX = CLK_FREQ / (2 * 262);
  localparam int unsigned HW     = (HP_MAX > 1) ? $clog2(HP_MAX) : 1;
  localparam int unsigned UW     = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

  typedef logic [HW-1:0] hp_t;
  typedef logic [UW-1:0] unit_t;

  localparam unit_t UNIT_LAST = UW'(UNIT_CYCLES - 1);

  // Terminal count (half-period minus one) per note index; entry 0 is a rest.
  localparam hp_t HP_LIM [16] = '{
    hp_t'(0),
    hp_t'(CLK_FREQ / (2 * 262)  - 1),
    hp_t'(CLK_FREQ / (2 * 294)  - 1),
    hp_t'(CLK_FREQ / (2 * 330)  - 1),
    hp_t'(CLK_FREQ / (2 * 349)  - 1),
    hp_t'(CLK_FREQ / (2 * 392)  - 1),
    hp_t'(CLK_FREQ / (2 * 440)  - 1),
    hp_t'(CLK_FREQ / (2 * 494)  - 1),
    hp_t'(CLK_FREQ / (2 * 523)  - 1),
    hp_t'(CLK_FREQ / (2 * 587)  - 1),
    hp_t'(CLK_FREQ / (2 * 659)  - 1),
    hp_t'(CLK_FREQ / (2 * 698)  - 1),
    hp_t'(CLK_FREQ / (2 * 784)  - 1),
    hp_t'(CLK_FREQ / (2 * 880)  - 1),
    hp_t'(CLK_FREQ / (2 * 988)  - 1),
    hp_t'(CLK_FREQ / (2 * 1047) - 1)
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PLAY  = 2'd2
  } state_t;

  state_t     state;
  logic       is_tone;
  hp_t        hp_lim;
  hp_t        hp_cnt;
  unit_t      unit_cnt;
  logic [3:0] units_left;

  // Player FSM with registered outputs; stop_sig outranks end-of-note.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      read_req_sig <= 1'b0;
      busy_sig     <= 1'b0;
      done_sig     <= 1'b0;
      Pin_Out      <= 1'b0;
      is_tone      <= 1'b0;
      hp_lim       <= '0;
      hp_cnt       <= '0;
      unit_cnt     <= '0;
      units_left   <= '0;
    end else begin
      done_sig <= 1'b0;
      case (state)
        IDLE: begin
          Pin_Out <= 1'b0;
          if (read_req_sig) begin
            // Pop already issued this cycle; the byte is on the bus next cycle.
            read_req_sig <= 1'b0;
            busy_sig     <= 1'b1;
            state        <= FETCH;
          end else if (!empty_sig && !stop_sig) begin
            read_req_sig <= 1'b1;
            busy_sig     <= 1'b1;
          end else begin
            busy_sig <= 1'b0;
          end
        end

        FETCH: begin
          Pin_Out <= 1'b0;
          if (stop_sig) begin
            busy_sig <= 1'b0;
            state    <= IDLE;
          end else begin
            is_tone    <= |FIFO_read_data[7:4];
            hp_lim     <= HP_LIM[FIFO_read_data[7:4]];
            units_left <= FIFO_read_data[3:0];
            hp_cnt     <= '0;
            unit_cnt   <= '0;
            state      <= PLAY;
          end
        end

        PLAY: begin
          if (stop_sig) begin
            Pin_Out  <= 1'b0;
            busy_sig <= 1'b0;
            hp_cnt   <= '0;
            unit_cnt <= '0;
            state    <= IDLE;
          end else if (unit_cnt == UNIT_LAST && units_left == 4'd0) begin
            // Last cycle of the last unit: finish low and chain the next pop.
            Pin_Out      <= 1'b0;
            done_sig     <= 1'b1;
            hp_cnt       <= '0;
            unit_cnt     <= '0;
            read_req_sig <= !empty_sig;
            busy_sig     <= !empty_sig;
            state        <= IDLE;
          end else begin
            if (unit_cnt == UNIT_LAST) begin
              unit_cnt   <= '0;
              units_left <= units_left - 4'd1;
            end else begin
              unit_cnt <= unit_cnt + UW'(1);
            end
            if (is_tone) begin
              if (hp_cnt == hp_lim) begin
                hp_cnt  <= '0;
                Pin_Out <= ~Pin_Out;
              end else begin
                hp_cnt <= hp_cnt + HW'(1);
              end
            end
          end
        end

        default: begin
          Pin_Out      <= 1'b0;
          read_req_sig <= 1'b0;
          busy_sig     <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_beep_player_module.sv
// Self-checking bench for beep_player_module: randomized note commands are
// checked against a waveform model derived from the note frequency table.
module tb_beep_player_module;

  localparam int unsigned TB_CLK  = 50_000;
  localparam int unsigned TB_UNIT = 20;

  localparam int FREQ_TAB [16] = '{0, 262, 294, 330, 349, 392, 440, 494,
                                   523, 587, 659, 698, 784, 880, 988, 1047};

  logic       CLK;
  logic       RST;
  logic       empty_sig;
  logic       read_req_sig;
  logic [7:0] FIFO_read_data;
  logic       stop_sig;
  logic       Pin_Out;
  logic       busy_sig;
  logic       done_sig;

  int n_cmp = 0;
  int n_bad = 0;
  int pops  = 0;
  logic [7:0] fifo_q [$];

  beep_player_module #(
    .CLK_FREQ   (TB_CLK),
    .UNIT_CYCLES(TB_UNIT)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .empty_sig     (empty_sig),
    .read_req_sig  (read_req_sig),
    .FIFO_read_data(FIFO_read_data),
    .stop_sig      (stop_sig),
    .Pin_Out       (Pin_Out),
    .busy_sig      (busy_sig),
    .done_sig      (done_sig)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Expected half-period in cycles; 0 means a rest.
  function automatic int ref_hp(input int n);
    if (n == 0) return 0;
    return int'(TB_CLK) / (2 * FREQ_TAB[n]);
  endfunction

  // One clock: the FIFO model serves a pop requested in the cycle just ended.
  task automatic step();
    bit req;
    req = read_req_sig;
    @(posedge CLK);
    #1;
    if (req) begin
      n_cmp++;
      if (fifo_q.size() == 0) begin
        n_bad++;
        $display("FAIL pop_while_empty: read_req_sig=1 with empty FIFO, required no pop");
      end else begin
        FIFO_read_data = fifo_q.pop_front();
        pops++;
      end
    end
    empty_sig = (fifo_q.size() == 0);
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    empty_sig = 1'b0;
  endtask

  // Current cycle must be the pop-request cycle; ends on the done cycle.
  task automatic play_note(input logic [7:0] cmd, input string tag);
    int hp, len, bad, first_bad;
    logic exp_pin, exp_req;
    hp  = ref_hp(int'(cmd[7:4]));
    len = (int'(cmd[3:0]) + 1) * int'(TB_UNIT);
    n_cmp++;
    if (read_req_sig !== 1'b1 || busy_sig !== 1'b1) begin
      n_bad++;
      $display("FAIL %s req_cycle: req=%b busy=%b, required 1 1", tag, read_req_sig, busy_sig);
    end
    step();
    n_cmp++;
    if (read_req_sig !== 1'b0 || busy_sig !== 1'b1 || Pin_Out !== 1'b0) begin
      n_bad++;
      $display("FAIL %s fetch: req=%b busy=%b pin=%b, required 0 1 0", tag, read_req_sig, busy_sig, Pin_Out);
    end
    step();
    bad = 0;
    first_bad = -1;
    for (int k = 0; k < len; k++) begin
      exp_pin = (hp == 0) ? 1'b0 : 1'((k / hp) % 2);
      if (Pin_Out !== exp_pin || busy_sig !== 1'b1 || done_sig !== 1'b0 || read_req_sig !== 1'b0) begin
        if (first_bad < 0) first_bad = k;
        bad++;
      end
      step();
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL %s play_wave cmd=%h: %0d bad cycles (first at %0d), required 0", tag, cmd, bad, first_bad);
    end
    exp_req = (fifo_q.size() != 0);
    n_cmp++;
    if (done_sig !== 1'b1 || Pin_Out !== 1'b0 || read_req_sig !== exp_req || busy_sig !== exp_req) begin
      n_bad++;
      $display("FAIL %s end_of_note: done=%b pin=%b req=%b busy=%b, required 1 0 %b %b",
               tag, done_sig, Pin_Out, read_req_sig, busy_sig, exp_req, exp_req);
    end
  endtask

  task automatic test_reset();
    int noisy;
    RST = 1'b1;
    step();
    step();
    n_cmp++;
    if (read_req_sig !== 1'b0 || Pin_Out !== 1'b0 || busy_sig !== 1'b0 || done_sig !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_values: req=%b pin=%b busy=%b done=%b, required 0 0 0 0",
               read_req_sig, Pin_Out, busy_sig, done_sig);
    end
    RST = 1'b0;
    noisy = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (read_req_sig !== 1'b0 || Pin_Out !== 1'b0 || busy_sig !== 1'b0 || done_sig !== 1'b0) noisy++;
    end
    n_cmp++;
    if (noisy !== 0) begin
      n_bad++;
      $display("FAIL idle_quiet: %0d active cycles with empty FIFO, required 0", noisy);
    end
  endtask

  task automatic test_single_note();
    logic [7:0] cmd;
    for (int i = 0; i < 3; i++) begin
      cmd = {4'($urandom_range(1, 15)), 4'($urandom_range(0, 3))};
      push(cmd);
      step();
      n_cmp++;
      if (read_req_sig !== 1'b1) begin
        n_bad++;
        $display("FAIL pop_latency: read_req_sig=%b, required 1", read_req_sig);
      end
      play_note(cmd, "single");
      step();
      n_cmp++;
      if (done_sig !== 1'b0 || busy_sig !== 1'b0 || read_req_sig !== 1'b0 || Pin_Out !== 1'b0) begin
        n_bad++;
        $display("FAIL single_after: done=%b busy=%b req=%b pin=%b, required 0 0 0 0",
                 done_sig, busy_sig, read_req_sig, Pin_Out);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] c1, c2;
    int p0, extra;
    c1 = {4'h0, 4'($urandom_range(0, 3))};
    c2 = {4'($urandom_range(1, 15)), 4'($urandom_range(0, 3))};
    p0 = pops;
    push(c1);
    push(c2);
    step();
    play_note(c1, "b2b_rest");
    play_note(c2, "b2b_tone");
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (read_req_sig !== 1'b0) extra++;
    end
    n_cmp++;
    if (extra !== 0 || pops - p0 !== 2) begin
      n_bad++;
      $display("FAIL b2b_pops: pops=%0d extra_req=%0d, required 2 0", pops - p0, extra);
    end
  endtask

  task automatic test_stop();
    logic [7:0] c1, c2;
    int k, act;
    c1 = {4'($urandom_range(1, 15)), 4'hF};
    c2 = {4'h2, 4'($urandom_range(0, 2))};
    push(c1);
    step();
    step();
    step();
    k = $urandom_range(1, 16 * TB_UNIT - 2);
    repeat (k) step();
    push(c2);
    stop_sig = 1'b1;
    step();
    n_cmp++;
    if (Pin_Out !== 1'b0 || done_sig !== 1'b0 || busy_sig !== 1'b0 || read_req_sig !== 1'b0) begin
      n_bad++;
      $display("FAIL stop_abort: pin=%b done=%b busy=%b req=%b, required 0 0 0 0",
               Pin_Out, done_sig, busy_sig, read_req_sig);
    end
    act = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (read_req_sig !== 1'b0 || done_sig !== 1'b0 || busy_sig !== 1'b0) act++;
    end
    n_cmp++;
    if (act !== 0) begin
      n_bad++;
      $display("FAIL stop_hold: %0d active cycles while stopped, required 0", act);
    end
    stop_sig = 1'b0;
    step();
    n_cmp++;
    if (read_req_sig !== 1'b1) begin
      n_bad++;
      $display("FAIL stop_release_pop: read_req_sig=%b, required 1", read_req_sig);
    end
    play_note(c2, "after_stop");
    step();
  endtask

  task automatic test_reset_mid();
    logic [7:0] c1, c2;
    c1 = {4'($urandom_range(1, 15)), 4'($urandom_range(1, 3))};
    c2 = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 2))};
    push(c1);
    step();
    step();
    step();
    repeat ($urandom_range(1, 10)) step();
    push(c2);
    RST = 1'b1;
    step();
    n_cmp++;
    if (read_req_sig !== 1'b0 || Pin_Out !== 1'b0 || busy_sig !== 1'b0 || done_sig !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid: req=%b pin=%b busy=%b done=%b, required 0 0 0 0",
               read_req_sig, Pin_Out, busy_sig, done_sig);
    end
    RST = 1'b0;
    step();
    n_cmp++;
    if (read_req_sig !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release_pop: read_req_sig=%b, required 1", read_req_sig);
    end
    play_note(c2, "after_reset");
    step();
  endtask

  task automatic test_stop_end();
    logic [7:0] c1, c2;
    int len, act;
    c1 = {4'($urandom_range(1, 15)), 4'($urandom_range(0, 2))};
    c2 = {4'($urandom_range(1, 15)), 4'($urandom_range(0, 1))};
    len = (int'(c1[3:0]) + 1) * int'(TB_UNIT);
    push(c1);
    push(c2);
    step();
    step();
    step();
    repeat (len - 1) step();
    stop_sig = 1'b1;
    step();
    n_cmp++;
    if (done_sig !== 1'b0 || Pin_Out !== 1'b0 || read_req_sig !== 1'b0 || busy_sig !== 1'b0) begin
      n_bad++;
      $display("FAIL stop_at_end: done=%b pin=%b req=%b busy=%b, required 0 0 0 0",
               done_sig, Pin_Out, read_req_sig, busy_sig);
    end
    act = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (read_req_sig !== 1'b0 || done_sig !== 1'b0) act++;
    end
    n_cmp++;
    if (act !== 0) begin
      n_bad++;
      $display("FAIL stop_end_hold: %0d active cycles while stopped, required 0", act);
    end
    stop_sig = 1'b0;
    step();
    n_cmp++;
    if (read_req_sig !== 1'b1) begin
      n_bad++;
      $display("FAIL stop_end_release_pop: read_req_sig=%b, required 1", read_req_sig);
    end
    play_note(c2, "after_stop_end");
    step();
  endtask

  initial begin
    RST            = 1'b1;
    empty_sig      = 1'b1;
    stop_sig       = 1'b0;
    FIFO_read_data = 8'h00;
    test_reset();
    test_single_note();
    test_back_to_back();
    test_stop();
    test_reset_mid();
    test_stop_end();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
